// File: rtl/vr16_pkg.sv
// Shared definitions for the vr16 core: register indices, fetch FSM encoding
// and the write-bypass match helper used by the operand path.
package vr16_pkg;

  localparam logic [1:0] REG_A = 2'd0;
  localparam logic [1:0] REG_B = 2'd1;
  localparam logic [1:0] REG_C = 2'd2;
  localparam logic [1:0] REG_D = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } fetch_state_t;

  // True when a register-file write this edge targets the given register.
  function automatic logic bypass_hit(input logic       write_enable,
                                      input logic [1:0] store_at,
                                      input logic [1:0] sel);
    return write_enable && (store_at == sel);
  endfunction

endpackage

// File: rtl/operand_mux.sv
// 4:1 register-file read select; a same-edge write to the selected register
// forwards alu_result so the freshest value is captured.
module operand_mux
  import vr16_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [1:0]            sel,
  input  logic [DATA_WIDTH-1:0] reg_a_in,
  input  logic [DATA_WIDTH-1:0] reg_b_in,
  input  logic [DATA_WIDTH-1:0] reg_c_in,
  input  logic [DATA_WIDTH-1:0] reg_d_in,
  input  logic                  write_enable,
  input  logic [1:0]            store_at,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic [DATA_WIDTH-1:0] data
);

  always_comb begin
    data = reg_a_in;
    unique case (sel)
      REG_A:   data = reg_a_in;
      REG_B:   data = reg_b_in;
      REG_C:   data = reg_c_in;
      REG_D:   data = reg_d_in;
      default: data = reg_a_in;
    endcase
    if (bypass_hit(write_enable, store_at, sel)) data = alu_result;
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: accepts decoder read requests, captures two operands
// with write bypass, and holds them (tracking writes) until the ALU consumes.
module operand_fetch
  import vr16_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            src_a_sel,
  input  logic [1:0]            src_b_sel,
  input  logic [DATA_WIDTH-1:0] reg_a_in,
  input  logic [DATA_WIDTH-1:0] reg_b_in,
  input  logic [DATA_WIDTH-1:0] reg_c_in,
  input  logic [DATA_WIDTH-1:0] reg_d_in,
  input  logic                  write_enable,
  input  logic [1:0]            store_at,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic                  op_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] operand_a,
  output logic [DATA_WIDTH-1:0] operand_b,
  output logic [CNT_WIDTH-1:0]  fetch_count
);

  fetch_state_t          state, state_nxt;
  logic                  accept;
  logic [DATA_WIDTH-1:0] opa_p0, opb_p0;
  logic [DATA_WIDTH-1:0] opa_p1, opb_p1;
  logic [1:0]            sel_a_p1, sel_b_p1;
  logic [CNT_WIDTH-1:0]  cnt_p1;

  assign accept = req_valid && req_ready;

  operand_mux #(.DATA_WIDTH(DATA_WIDTH)) u_mux_a (
    .sel          (src_a_sel),
    .reg_a_in     (reg_a_in),
    .reg_b_in     (reg_b_in),
    .reg_c_in     (reg_c_in),
    .reg_d_in     (reg_d_in),
    .write_enable (write_enable),
    .store_at     (store_at),
    .alu_result   (alu_result),
    .data         (opa_p0)
  );

  operand_mux #(.DATA_WIDTH(DATA_WIDTH)) u_mux_b (
    .sel          (src_b_sel),
    .reg_a_in     (reg_a_in),
    .reg_b_in     (reg_b_in),
    .reg_c_in     (reg_c_in),
    .reg_d_in     (reg_d_in),
    .write_enable (write_enable),
    .store_at     (store_at),
    .alu_result   (alu_result),
    .data         (opb_p0)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = HOLD;
      HOLD:    if (out_ready && !req_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    op_valid  = (state == HOLD);
    req_ready = (state == IDLE) || out_ready;
  end

  // ---- stage p0 -> p1: operand capture and stall-time write tracking ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      opa_p1   <= '0;
      opb_p1   <= '0;
      sel_a_p1 <= REG_A;
      sel_b_p1 <= REG_A;
    end else if (accept) begin
      opa_p1   <= opa_p0;
      opb_p1   <= opb_p0;
      sel_a_p1 <= src_a_sel;
      sel_b_p1 <= src_b_sel;
    end else if (state == HOLD && !out_ready) begin
      if (bypass_hit(write_enable, store_at, sel_a_p1)) opa_p1 <= alu_result;
      if (bypass_hit(write_enable, store_at, sel_b_p1)) opb_p1 <= alu_result;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      cnt_p1 <= '0;
    else if (accept) cnt_p1 <= cnt_p1 + CNT_WIDTH'(1);
  end

  assign operand_a   = opa_p1;
  assign operand_b   = opb_p1;
  assign fetch_count = cnt_p1;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: fetch, bypass, stall tracking,
// back-to-back streaming, counter wrap and asynchronous reset mid-hold.
module tb_operand_fetch;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  src_a_sel, src_b_sel;
  logic [15:0] reg_a_in, reg_b_in, reg_c_in, reg_d_in;
  logic        write_enable;
  logic [1:0]  store_at;
  logic [15:0] alu_result;
  logic        op_valid;
  logic        out_ready;
  logic [15:0] operand_a, operand_b;
  logic [7:0]  fetch_count;

  int n_checks = 0;
  int n_fail   = 0;

  operand_fetch #(.DATA_WIDTH(16), .CNT_WIDTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .src_a_sel    (src_a_sel),
    .src_b_sel    (src_b_sel),
    .reg_a_in     (reg_a_in),
    .reg_b_in     (reg_b_in),
    .reg_c_in     (reg_c_in),
    .reg_d_in     (reg_d_in),
    .write_enable (write_enable),
    .store_at     (store_at),
    .alu_result   (alu_result),
    .op_valid     (op_valid),
    .out_ready    (out_ready),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .fetch_count  (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1; req_valid = 0; out_ready = 0;
    src_a_sel = 0; src_b_sel = 0;
    reg_a_in = 0; reg_b_in = 0; reg_c_in = 0; reg_d_in = 0;
    write_enable = 0; store_at = 0; alu_result = 0;
    #1 reset = 1'b0;
    #1;
    check("rst_op_valid", op_valid, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_opa", operand_a, 0);
    check("rst_opb", operand_b, 0);
    check("rst_count", fetch_count, 0);
    req_valid = 1;
    step();
    check("rst_no_accept", fetch_count, 0);
    req_valid = 0;
    @(negedge clk) reset = 1'b1;

    // basic fetch
    reg_b_in = 16'h1234; reg_d_in = 16'hBEEF;
    src_a_sel = 2'b01; src_b_sel = 2'b11; req_valid = 1;
    #1 check("idle_req_ready", req_ready, 1);
    step();
    check("basic_valid", op_valid, 1);
    check("basic_opa", operand_a, 16'h1234);
    check("basic_opb", operand_b, 16'hBEEF);
    check("basic_count", fetch_count, 1);
    req_valid = 0;
    #1 check("hold_not_ready", req_ready, 0);
    // stable in hold: register changes and an unrelated write must not leak in
    reg_b_in = 16'h5555; write_enable = 1; store_at = 2'b00; alu_result = 16'h9999;
    step();
    check("hold_stable_opa", operand_a, 16'h1234);
    check("hold_stable_opb", operand_b, 16'hBEEF);
    check("hold_stable_valid", op_valid, 1);
    write_enable = 0; out_ready = 1;
    step();
    check("drain_valid", op_valid, 0);
    check("drain_opa_kept", operand_a, 16'h1234);
    // writes in IDLE are ignored
    write_enable = 1; store_at = 2'b01; alu_result = 16'h7777; out_ready = 0;
    step();
    check("idle_ignore_we", operand_a, 16'h1234);

    // capture bypass on operand A only
    reg_a_in = 16'h1111; reg_c_in = 16'h0001;
    src_a_sel = 2'b10; src_b_sel = 2'b00;
    store_at = 2'b10; alu_result = 16'h00FF; req_valid = 1;
    step();
    check("bypass_opa", operand_a, 16'h00FF);
    check("bypass_opb", operand_b, 16'h1111);
    check("bypass_count", fetch_count, 2);
    req_valid = 0; write_enable = 0; out_ready = 1;
    step();
    check("bypass_drain", op_valid, 0);

    // same sel on both operands under bypass
    src_a_sel = 2'b11; src_b_sel = 2'b11;
    write_enable = 1; store_at = 2'b11; alu_result = 16'hCAFE; req_valid = 1; out_ready = 0;
    step();
    check("samesel_opa", operand_a, 16'hCAFE);
    check("samesel_opb", operand_b, 16'hCAFE);
    check("samesel_count", fetch_count, 3);
    req_valid = 0; write_enable = 0; out_ready = 1;
    step();

    // stall tracking
    reg_a_in = 16'h2222; src_a_sel = 2'b00; src_b_sel = 2'b00;
    req_valid = 1; out_ready = 0;
    step();
    check("stall_cap_opa", operand_a, 16'h2222);
    check("stall_count", fetch_count, 4);
    req_valid = 0; write_enable = 1; store_at = 2'b00; alu_result = 16'hA5A5;
    step();
    check("track_opa", operand_a, 16'hA5A5);
    check("track_opb", operand_b, 16'hA5A5);
    check("track_valid", op_valid, 1);
    write_enable = 0; out_ready = 1;
    step();
    check("track_drain", op_valid, 0);

    // back-to-back streaming
    src_a_sel = 2'b00; src_b_sel = 2'b01; req_valid = 1; out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      reg_a_in = 16'h1000 + 16'(k);
      reg_b_in = 16'h2000 + 16'(k);
      step();
      check("b2b_valid", op_valid, 1);
      check("b2b_opa", operand_a, 16'h1000 + 16'(k));
      check("b2b_opb", operand_b, 16'h2000 + 16'(k));
      check("b2b_count", fetch_count, 5 + k);
    end
    req_valid = 0;
    step();
    check("b2b_idle", op_valid, 0);

    // asynchronous reset mid-hold
    req_valid = 1; out_ready = 0;
    step();
    check("pre_rst_valid", op_valid, 1);
    req_valid = 0;
    reset = 1'b0;
    #1;
    check("midrst_valid", op_valid, 0);
    check("midrst_opa", operand_a, 0);
    check("midrst_opb", operand_b, 0);
    check("midrst_count", fetch_count, 0);
    check("midrst_ready", req_ready, 1);
    @(negedge clk) reset = 1'b1;

    // counter wrap
    req_valid = 1; out_ready = 1;
    for (int i = 0; i < 256; i++) begin
      step();
      if (i == 254) check("wrap_255th", fetch_count, 8'hFF);
    end
    check("wrap_256th", fetch_count, 8'h00);
    check("wrap_valid", op_valid, 1);
    req_valid = 0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning the width of registers and operands.
REQ-002 SHALL have parameter CNT_WIDTH, default 8, meaning the width of the fetch counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, 1 bit: the decoder presents a read request.
REQ-006 SHALL have port req_ready, output, 1 bit: the block accepts the request this cycle.
REQ-007 SHALL have port src_a_sel, input, 2 bits: register index for operand A (00=a, 01=b, 10=c, 11=d).
REQ-008 SHALL have port src_b_sel, input, 2 bits: register index for operand B, same encoding.
REQ-009 SHALL have ports reg_a_in, reg_b_in, reg_c_in and reg_d_in, each an input of DATA_WIDTH bits: current register-file contents.
REQ-010 SHALL have port write_enable, input, 1 bit: a register-file write occurs at this edge.
REQ-011 SHALL have port store_at, input, 2 bits: the register-file write target.
REQ-012 SHALL have port alu_result, input, DATA_WIDTH bits: the register-file write data.
REQ-013 SHALL have port op_valid, output, 1 bit: the operands are valid.
REQ-014 SHALL have port out_ready, input, 1 bit: the ALU consumes the operands.
REQ-015 SHALL have ports operand_a and operand_b, each an output of DATA_WIDTH bits: the fetched operands.
REQ-016 SHALL have port fetch_count, output, CNT_WIDTH bits: the number of accepted requests.

Function
REQ-017 SHALL implement a two-state FSM: IDLE (no operands held) and HOLD (operands held, op_valid=1).
REQ-018 SHALL drive req_ready = (state==IDLE) | out_ready, combinationally; a request is accepted when req_valid & req_ready.
REQ-019 SHALL perform the following on acceptance: capture the selected operands and the latched sel values at that edge, enter HOLD, and assert op_valid the next cycle (one-cycle latency).
REQ-020 SHALL make these transitions:
- IDLE + accept -> HOLD.
- HOLD + out_ready + req_valid -> HOLD with new operands (back-to-back, no bubble).
- HOLD + out_ready + !req_valid -> IDLE.
- HOLD + !out_ready -> HOLD with the hold condition applied.
REQ-021 SHALL apply the capture bypass: if write_enable and store_at equals a source sel in the accept cycle, capture alu_result for that operand instead of reg_*_in.
REQ-022 SHALL apply hold tracking: in HOLD without consumption, if write_enable and store_at equals a latched sel, replace that operand with alu_result; both operands update if both sels match.
REQ-023 SHALL keep operand_a and operand_b stable in HOLD except under REQ-022.
REQ-024 SHALL handle src_a_sel==src_b_sel by giving both operands the identical value, including under bypass.
REQ-025 SHALL increment fetch_count by 1 per accepted request, wrapping from 2^CNT_WIDTH-1 to 0, with no saturation.
REQ-026 SHALL keep operands unchanged in IDLE and ignore write_enable there.

Reset
REQ-027 SHALL respond to reset low immediately, without waiting for clk: state=IDLE, op_valid=0, operand_a=0, operand_b=0, latched sels=0, fetch_count=0.
REQ-028 SHALL drive req_ready=1 while in reset, with no acceptance occurring.
REQ-029 SHALL discard held operands if reset asserts mid-HOLD, so that op_valid=0 with no partial output.
REQ-030 SHALL evaluate its first accept at the first rising clk edge with reset high.

Structure
REQ-031 SHALL define the register index constants (REG_A..REG_D) and the FSM state encoding in shared package vr16_pkg, which gp_registers and the decoder also use.
REQ-032 SHALL use one sub-module, operand_mux: 4:1 register select with write bypass, instantiated twice (A and B).
REQ-033 SHALL place the FSM, the holding registers and the counter in operand_fetch itself.

Verification
REQ-034 SHALL cover basic fetch: reg_b_in=0x1234, reg_d_in=0xBEEF, sel_a=01, sel_b=11, accept -> next cycle op_valid=1, operand_a=0x1234, operand_b=0xBEEF, fetch_count=1.
REQ-035 SHALL cover bypass: accept sel_a=10 while write_enable=1, store_at=10, alu_result=0x00FF, reg_c_in=0x0001 -> operand_a=0x00FF.
REQ-036 SHALL cover stall tracking: HOLD with sel_a=sel_b=00, out_ready=0, write_enable=1, store_at=00, alu_result=0xA5A5 -> next cycle operand_a=operand_b=0xA5A5, op_valid remains 1.
REQ-037 SHALL cover back-to-back: req_valid and out_ready both held high for 4 cycles -> op_valid stays 1 throughout, 4 distinct operand pairs appear, and fetch_count advances by 4.
REQ-038 SHALL cover wrap: 256 accepts from reset -> fetch_count=0x00, and the 255th accept gives 0xFF.
REQ-039 SHALL cover reset mid-HOLD: reset low asynchronously between edges -> op_valid, operands and fetch_count read 0 before the next clk edge.
